// File: rtl/uart_tx_fifo_if.sv
// Host-side bundle of the UART transmitter: FIFO write port, enable and line/status outputs.
interface uart_tx_fifo_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [DATA_BITS-1:0] tx_data;
   logic                 ld_tx_data;
   logic                 tx_enable;
   logic                 tx_out;
   logic                 tx_empty;
   logic                 tx_full;
   logic                 tx_busy;
   logic [CW-1:0]        fifo_count;

   modport master (
      output tx_data, ld_tx_data, tx_enable,
      input  tx_out, tx_empty, tx_full, tx_busy, fifo_count
   );

   modport slave (
      input  tx_data, ld_tx_data, tx_enable,
      output tx_out, tx_empty, tx_full, tx_busy, fifo_count
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a circular transmit FIFO, configurable frame format and built-in baud divider.
// Outputs are registered from next-state lookahead so the start bit appears on the pop edge.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic          clk,
   input  logic          reset,
   uart_tx_fifo_if.slave bus
);
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int CW     = AW + 1;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_BITS);

   localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);
   localparam logic [CW-1:0]     FULL_CNT  = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

   state_t               state, state_nxt;
   logic [BAUD_W-1:0]    baud_cnt, baud_nxt;
   logic [BIT_W-1:0]     bit_cnt, bit_nxt;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        count, count_nxt;
   logic [DATA_BITS-1:0] frame_data, data_nxt;

   logic                 push, pop, bit_done, start_ok;
   logic                 tx_out_q, tx_out_nxt;
   logic                 busy_q, busy_nxt;
   logic                 empty_q, empty_nxt;
   logic                 full_q;

   // A write into a full FIFO is dropped even when a pop happens in the same cycle.
   assign push      = bus.ld_tx_data && !full_q;
   assign bit_done  = (baud_cnt == LAST_BAUD);
   assign start_ok  = bus.tx_enable && (count != '0);
   assign count_nxt = count + CW'(push) - CW'(pop);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_nxt;
         bit_cnt  <= bit_nxt;
      end
   end

   // NOTE: every variable gets a default at the top of a combinational block so no latch is inferred.
   always_comb begin
      state_nxt = state;
      baud_nxt  = baud_cnt + BAUD_W'(1);
      bit_nxt   = bit_cnt;
      pop       = 1'b0;
      case (state)
         ST_IDLE: begin
            baud_nxt = '0;
            if (start_ok) begin
               pop       = 1'b1;
               state_nxt = ST_START;
               bit_nxt   = '0;
            end
         end
         ST_START: begin
            if (bit_done) begin
               state_nxt = ST_DATA;
               baud_nxt  = '0;
               bit_nxt   = '0;
            end
         end
         ST_DATA: begin
            if (bit_done) begin
               baud_nxt = '0;
               if (bit_cnt == LAST_DATA) begin
                  state_nxt = (PARITY != 0) ? ST_PARITY : ST_STOP;
                  bit_nxt   = '0;
               end else begin
                  bit_nxt = bit_cnt + BIT_W'(1);
               end
            end
         end
         ST_PARITY: begin
            if (bit_done) begin
               state_nxt = ST_STOP;
               baud_nxt  = '0;
               bit_nxt   = '0;
            end
         end
         ST_STOP: begin
            if (bit_done) begin
               baud_nxt = '0;
               if (bit_cnt == LAST_STOP) begin
                  bit_nxt = '0;
                  // Chain straight into the next start bit when a word is already waiting.
                  if (start_ok) begin
                     pop       = 1'b1;
                     state_nxt = ST_START;
                  end else begin
                     state_nxt = ST_IDLE;
                  end
               end else begin
                  bit_nxt = bit_cnt + BIT_W'(1);
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            baud_nxt  = '0;
            bit_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      data_nxt = pop ? mem[rd_ptr] : frame_data;
      case (state_nxt)
         ST_START:  tx_out_nxt = 1'b0;
         ST_DATA:   tx_out_nxt = data_nxt[bit_nxt];
         ST_PARITY: tx_out_nxt = (PARITY == 1) ? ~^data_nxt : ^data_nxt;
         default:   tx_out_nxt = 1'b1;
      endcase
      busy_nxt  = (state_nxt != ST_IDLE);
      empty_nxt = (count_nxt == '0) && !busy_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         frame_data <= '0;
         tx_out_q   <= 1'b1;
         busy_q     <= 1'b0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count      <= count_nxt;
         frame_data <= data_nxt;
         tx_out_q   <= tx_out_nxt;
         busy_q     <= busy_nxt;
         empty_q    <= empty_nxt;
         full_q     <= (count_nxt == FULL_CNT);
      end
   end

   // NOTE: storage array has no reset; the pointers and count define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.tx_data;
   end

   assign bus.tx_out     = tx_out_q;
   assign bus.tx_busy    = busy_q;
   assign bus.tx_empty   = empty_q;
   assign bus.tx_full    = full_q;
   assign bus.fifo_count = count;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four formats (8N1, 8E1, 8O1, 7E2) share one stimulus stream,
// each line is decoded cycle-by-cycle against a queue of words expected on that line.
module tb_uart_tx_fifo;
   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] wdata;
   logic       ld;
   logic       en;
   logic [3:0] lines;

   int n_checks = 0;
   int n_pass   = 0;
   int frames  [4];
   int gap_sum [4];

   logic [7:0] q0[$], q1[$], q2[$], q3[$];

   uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_n (), if_e (), if_o ();
   uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if_7 ();

   assign if_n.tx_data = wdata;       assign if_e.tx_data = wdata;
   assign if_o.tx_data = wdata;       assign if_7.tx_data = wdata[6:0];
   assign if_n.ld_tx_data = ld;       assign if_e.ld_tx_data = ld;
   assign if_o.ld_tx_data = ld;       assign if_7.ld_tx_data = ld;
   assign if_n.tx_enable = en;        assign if_e.tx_enable = en;
   assign if_o.tx_enable = en;        assign if_7.tx_enable = en;
   assign lines = {if_7.tx_out, if_o.tx_out, if_e.tx_out, if_n.tx_out};

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
      dut_n (.clk(clk), .reset(reset), .bus(if_n));
   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
      dut_e (.clk(clk), .reset(reset), .bus(if_e));
   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
      dut_o (.clk(clk), .reset(reset), .bus(if_o));
   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4))
      dut_7 (.clk(clk), .reset(reset), .bus(if_7));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic int q_size(input int k);
      case (k)
         0:       return q0.size();
         1:       return q1.size();
         2:       return q2.size();
         default: return q3.size();
      endcase
   endfunction

   function automatic logic [7:0] q_pop(input int k);
      case (k)
         0:       return q0.pop_front();
         1:       return q1.pop_front();
         2:       return q2.pop_front();
         default: return q3.pop_front();
      endcase
   endfunction

   // Drive one word for one cycle; accepted words become expected frames on every line.
   task automatic write(input logic [7:0] d, input bit accepted);
      wdata = d;
      ld    = 1'b1;
      if (accepted) begin
         q0.push_back(d);
         q1.push_back(d);
         q2.push_back(d);
         q3.push_back(d & 8'h7F);
      end
      @(negedge clk);
      ld = 1'b0;
   endtask

   task automatic clear_stats();
      for (int k = 0; k < 4; k++) begin
         frames[k]  = 0;
         gap_sum[k] = 0;
      end
   endtask

   task automatic drain(input string tag, input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         done = if_n.tx_empty && if_e.tx_empty && if_o.tx_empty && if_7.tx_empty &&
                q0.size() == 0 && q1.size() == 0 && q2.size() == 0 && q3.size() == 0;
      end
      check(tag, done, 1);
      repeat (2) @(negedge clk);
   endtask

   // Decode line k: every cycle of a frame must equal the bit expected for that position.
   task automatic monitor(input int k, input int nb, input int par, input int sb);
      int          total, t0, bad, ones;
      int          last_end = -1000;
      logic [15:0] exp_bits, obs_bits;
      logic [7:0]  d;
      bit          have, aborted;
      total = 1 + nb + ((par != 0) ? 1 : 0) + sb;
      forever begin
         @(negedge clk);
         if (reset || lines[k]) continue;
         t0   = int'($time / 10);
         have = (q_size(k) != 0);
         check($sformatf("word_expected_%0d", k), have, 1);
         d = have ? q_pop(k) : 8'h00;
         ones     = $countones(d);
         exp_bits = '1;
         exp_bits[0] = 1'b0;
         for (int i = 0; i < nb; i++) exp_bits[1 + i] = d[i];
         if (par == 1) exp_bits[1 + nb] = (ones % 2 == 0);
         if (par == 2) exp_bits[1 + nb] = (ones % 2 == 1);
         obs_bits = '1;
         bad      = 0;
         aborted  = 1'b0;
         for (int c = 0; c < total * CPB; c++) begin
            if (c > 0) @(negedge clk);
            if (reset) begin
               aborted = 1'b1;
               break;
            end
            if (lines[k] !== exp_bits[c / CPB]) bad++;
            if (c % CPB == 1) obs_bits[c / CPB] = lines[k];
         end
         if (!aborted) begin
            check($sformatf("frame_bits_%0d_%02h", k, d), obs_bits, exp_bits);
            check($sformatf("bit_timing_%0d_%02h", k, d), bad, 0);
            if (frames[k] > 0) gap_sum[k] += t0 - last_end - 1;
            frames[k]++;
            last_end = t0 + total * CPB - 1;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int  maxc;
      bit  saw_low;
      reset = 1'b1;
      ld    = 1'b0;
      en    = 1'b0;
      wdata = 8'h00;
      clear_stats();
      fork
         monitor(0, 8, 0, 1);
         monitor(1, 8, 2, 1);
         monitor(2, 8, 1, 1);
         monitor(3, 7, 2, 2);
      join_none

      // Reset state
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_tx_out", if_n.tx_out, 1);
      check("rst_tx_empty", if_n.tx_empty, 1);
      check("rst_tx_full", if_n.tx_full, 0);
      check("rst_tx_busy", if_n.tx_busy, 0);
      check("rst_fifo_count", if_n.fifo_count, 0);
      check("rst_all_lines", lines, 4'hF);

      // Single word: count on the write edge, start bit one edge later
      en = 1'b1;
      write(8'hA5, 1);
      check("count_after_write", if_n.fifo_count, 1);
      check("no_same_cycle_pop", if_n.tx_out, 1);
      @(negedge clk);
      check("start_bit_low", if_n.tx_out, 0);
      check("busy_at_start", if_n.tx_busy, 1);
      check("empty_at_start", if_n.tx_empty, 0);
      drain("drain_a5", 200);
      check("empty_after_a5", if_n.tx_empty, 1);
      check("busy_after_a5", if_n.tx_busy, 0);
      write(8'h7F, 1);
      drain("drain_7f", 200);

      // Overflow with transmitter held off, then back-to-back burst
      en = 1'b0;
      for (int i = 1; i <= 6; i++) write(8'(i), i <= 4);
      check("count_full", if_n.fifo_count, 4);
      check("tx_full_set", if_n.tx_full, 1);
      check("count_full_7bit", if_7.fifo_count, 4);
      check("line_idle_disabled", lines, 4'hF);
      clear_stats();
      en = 1'b1;
      drain("drain_burst", 400);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("burst_frames_%0d", k), frames[k], 4);
         check($sformatf("burst_gaps_%0d", k), gap_sum[k], 0);
      end
      check("full_cleared", if_n.tx_full, 0);
      repeat (60) @(negedge clk);
      check("no_extra_frames", lines, 4'hF);

      // Enable dropped mid-frame: current frame completes, queued words wait
      en = 1'b0;
      write(8'h3C, 1);
      write(8'h11, 1);
      write(8'h22, 1);
      en = 1'b1;
      repeat (20) @(negedge clk);
      en = 1'b0;
      repeat (70) @(negedge clk);
      check("held_count", if_n.fifo_count, 2);
      check("held_line_high", if_n.tx_out, 1);
      check("held_busy", if_n.tx_busy, 0);
      check("held_empty", if_n.tx_empty, 0);
      check("held_words", q0.size(), 2);
      en = 1'b1;
      drain("drain_held", 400);

      // Reset during data bit 3 flushes the FIFO and aborts the frame
      write(8'h5A, 1);
      write(8'h77, 0);
      check("queued_before_reset", if_n.fifo_count, 1);
      repeat (17) @(negedge clk);
      check("busy_before_reset", if_n.tx_busy, 1);
      reset = 1'b1;
      @(negedge clk);
      check("abort_tx_out", if_n.tx_out, 1);
      check("abort_count", if_n.fifo_count, 0);
      check("abort_busy", if_n.tx_busy, 0);
      check("abort_empty", if_n.tx_empty, 1);
      reset = 1'b0;
      saw_low = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (lines != 4'hF) saw_low = 1'b1;
      end
      check("no_frame_after_reset", saw_low, 0);
      check("queues_after_reset", q_size(0) + q_size(3), 0);

      // Write landing on the edge that ends the final stop bit
      clear_stats();
      write(8'h81, 1);
      maxc = int'(if_n.fifo_count);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (int'(if_n.fifo_count) > maxc) maxc = int'(if_n.fifo_count);
      end
      write(8'hC3, 1);
      if (int'(if_n.fifo_count) > maxc) maxc = int'(if_n.fifo_count);
      check("late_write_count", if_n.fifo_count, 1);
      check("late_idle_cycle", if_n.tx_out, 1);
      @(negedge clk);
      check("late_start_bit", if_n.tx_out, 0);
      drain("drain_late", 200);
      check("late_max_count", maxc, 1);
      check("late_gap_8n1", gap_sum[0], 1);
      check("late_gap_7e2", gap_sum[3], 0);
      check("late_frames_8n1", frames[0], 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
